// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter paced by an external baud strobe.
// Takes a byte on a valid/ready handshake and sends start, data bits LSB first,
// optional parity and stop bits on the tx line.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   baud_tick - one-cycle strobe per bit period
//   data      - byte to send, latched on handshake
//   valid     - upstream presents a byte
//   ready     - block can accept a byte (IDLE)
//   tx        - serial output, idles high
//   busy      - frame in progress
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned STOP_W = $clog2(STOP_BITS + 1);

    // Reject unsupported parameter combinations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx_serializer: illegal DATA_BITS/PARITY/STOP_BITS");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [STOP_W-1:0]      stop_q, stop_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            par_q   <= par_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state and framing logic; tx only moves on a sampled baud_tick.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        par_d   = par_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (valid) begin
                    shift_d = data;
                    // Parity comes from the latched byte, so later data changes are harmless.
                    par_d   = (PARITY == 2) ? ~(^data) : (^data);
                    idx_d   = '0;
                    stop_d  = '0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                // IDLE consumed the transfer cycle, so any tick there is ignored.
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            stop_d  = '0;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    stop_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_q == STOP_W'(STOP_BITS - 1)) begin
                        stop_d  = '0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + STOP_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no parity/1 stop, even/1 stop,
// odd/2 stop) share one clock and a baud tick every 4 cycles. Stimulus pushes
// expected frames; per-instance monitors pop and compare each frame on tx.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] vld = 3'b000;
    logic [2:0] rdy, txs, bsy;
    logic [7:0] dat [3];

    int n_tests = 0;
    int n_fail  = 0;
    int tcnt    = 0;

    logic [15:0] exp_q [3][$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(rst[0]), .baud_tick(tick), .data(dat[0]), .valid(vld[0]),
        .ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(rst[1]), .baud_tick(tick), .data(dat[1]), .valid(vld[1]),
        .ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(rst[2]), .baud_tick(tick), .data(dat[2]), .valid(vld[2]),
        .ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));

    // Baud strobe: one cycle high every 4 clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nbits(input int i);
        return (i == 0) ? 10 : (i == 1) ? 11 : 12;
    endfunction

    // Frame bits in line order: bit0 = start, then data LSB first, parity, stops.
    function automatic logic [15:0] frame(input int i, input logic [7:0] b, input logic p);
        logic [15:0] f;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (i != 0) f[9] = p;
        return f;
    endfunction

    // Watches one instance's tx line and compares each frame with the queue head.
    task automatic monitor(input int i);
        logic [15:0] f, obs, mask;
        logic        prev;
        bit          bad, aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst[i]) begin
                prev = 1'b1;
                continue;
            end
            if (prev === 1'b1 && txs[i] === 1'b0) begin
                check(exp_q[i].size() != 0, "unexpected_frame", 32'(i), 32'(0));
                if (exp_q[i].size() != 0) begin
                    f       = exp_q[i].pop_front();
                    obs     = 16'hFFFF;
                    bad     = 1'b0;
                    aborted = 1'b0;
                    for (int s = 0; s < nbits(i) * 4; s++) begin
                        if (s > 0) @(negedge clk);
                        if (rst[i]) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (txs[i] !== f[s/4]) bad = 1'b1;
                        if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) bad = 1'b1;
                        obs[s/4] = txs[i];
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (!rst[i] && (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || txs[i] !== 1'b1))
                            bad = 1'b1;
                        mask = 16'((1 << nbits(i)) - 1);
                        check(!bad, $sformatf("frame_u%0d", i), 32'(obs & mask), 32'(f & mask));
                    end
                end
            end
            prev = txs[i];
        end
    endtask

    // Hand one byte over; optionally align the transfer with a tick.
    task automatic send(input int i, input logic [7:0] b, input logic p, input bit align);
        int n;
        bit bad;
        n = 0;
        @(posedge clk); #2;
        while (!(rdy[i] === 1'b1 && (!align || tick)) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check(n < 200, "ready_timeout", 32'(n), 32'(200));
        if (n < 200) begin
            dat[i] = b;
            vld[i] = 1'b1;
            @(posedge clk);
            exp_q[i].push_back(frame(i, b, p));
            #2;
            vld[i] = 1'b0;
            dat[i] = ~b;
            check(rdy[i] === 1'b0, "ready_drop", 32'(rdy[i]), 32'(0));
            if (align) begin
                bad = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (txs[i] !== 1'b1) bad = 1'b1;
                end
                @(negedge clk);
                if (txs[i] !== 1'b0) bad = 1'b1;
                check(!bad, "sync_wait", 32'(txs[i]), 32'(0));
            end
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q[i].size() == 0 && bsy[i] === 1'b0) && n < 600);
        check(n < 600, "idle_timeout", 32'(n), 32'(600));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  bad;
        logic [2:0] seen_low;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;

        // Reset and idle line.
        repeat (2) @(posedge clk);
        #2;
        rst = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(txs[i] === 1'b1, "reset_tx", 32'(txs[i]), 32'(1));
            check(rdy[i] === 1'b1, "reset_ready", 32'(rdy[i]), 32'(1));
            check(bsy[i] === 1'b0, "reset_busy", 32'(bsy[i]), 32'(0));
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        seen_low = 3'b000;
        repeat (80) begin
            @(negedge clk);
            seen_low = seen_low | ~txs;
        end
        for (int i = 0; i < 3; i++)
            check(seen_low[i] == 1'b0, "idle_high", 32'(seen_low[i]), 32'(0));

        // Plain frame, no parity.
        send(0, 8'hA5, 1'b0, 1'b0);
        wait_idle(0);

        // Even parity.
        send(1, 8'h07, 1'b1, 1'b0);
        wait_idle(1);
        send(1, 8'h00, 1'b0, 1'b0);
        wait_idle(1);

        // Odd parity, two stop bits.
        send(2, 8'h07, 1'b0, 1'b0);
        wait_idle(2);

        // Back-to-back with valid held: 0x3C waits behind 0xFF.
        send(2, 8'hFF, 1'b1, 1'b0);
        dat[2] = 8'h3C;
        vld[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy[2] !== 1'b1 && n < 200);
        check(n < 200, "b2b_ready_timeout", 32'(n), 32'(200));
        @(posedge clk);
        exp_q[2].push_back(frame(2, 8'h3C, 1'b1));
        #2;
        check(rdy[2] === 1'b0, "b2b_accept", 32'(rdy[2]), 32'(0));
        vld[2] = 1'b0;
        dat[2] = 8'h00;
        wait_idle(2);

        // Tick coincident with the transfer cycle.
        send(0, 8'hC3, 1'b0, 1'b1);
        wait_idle(0);

        // Reset during data bit 3 of 0x55, then a clean 0x81 frame.
        send(0, 8'h55, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txs[0] !== 1'b0 && n < 100);
        check(n < 100, "start_timeout", 32'(n), 32'(100));
        repeat (17) @(negedge clk);
        @(posedge clk); #2;
        rst[0] = 1'b1;
        @(posedge clk); #2;
        rst[0] = 1'b0;
        @(negedge clk);
        check(txs[0] === 1'b1, "midreset_tx", 32'(txs[0]), 32'(1));
        check(rdy[0] === 1'b1, "midreset_ready", 32'(rdy[0]), 32'(1));
        check(bsy[0] === 1'b0, "midreset_busy", 32'(bsy[0]), 32'(0));
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (txs[0] !== 1'b1) bad = 1'b1;
        end
        check(!bad, "midreset_no_resume", 32'(bad), 32'(0));
        send(0, 8'h81, 1'b0, 1'b0);
        wait_idle(0);

        // Let any duplicate frame show up, then confirm all expectations consumed.
        repeat (60) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check(exp_q[i].size() == 0, "queue_empty", 32'(exp_q[i].size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
